// File: rtl/mdr_mem_ctrl.sv
// Memory data register with a small read/write handshake FSM.
// Reads merge memory data into the register per byte lane; writes drive it out unchanged.
module mdr_mem_ctrl #(
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0,
  parameter int                 MAX_WAIT  = 15
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  enable,
  input  logic                  read_req,
  input  logic                  write_req,
  input  logic [DATA_W/8-1:0]   byte_en,
  input  logic [DATA_W-1:0]     BusMuxOut,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ready,
  output logic [DATA_W-1:0]     qOut,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout
);

  localparam int              NB      = DATA_W / 8;
  localparam int              CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  // Handshake: a request is taken only in IDLE; mem_ready is only looked at
  // while waiting, and a wait either completes on mem_ready or times out.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic [DATA_W-1:0]  q_q, q_d;
  logic               mem_rd_q, mem_rd_d;
  logic               mem_wr_q, mem_wr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (read_req) begin
          state_d = RD_WAIT;
        end else if (write_req) begin
          state_d = WR_WAIT;
        end else if (enable) begin
          q_d = BusMuxOut;
        end
      end

      RD_WAIT, WR_WAIT: begin
        if (mem_ready) begin
          // Completion wins even on the cycle the limit would be hit.
          if (state_q == RD_WAIT) begin
            for (int i = 0; i < NB; i++) begin
              if (byte_en[i]) begin
                q_d[8*i +: 8] = mem_rdata[8*i +: 8];
              end
            end
          end
          state_d = DONE;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_d   = IDLE;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Strobes are decoded from the next state so they line up with the state register.
  always_comb begin
    mem_rd_d = (state_d == RD_WAIT);
    mem_wr_d = (state_d == WR_WAIT);
    busy_d   = (state_d == RD_WAIT) || (state_d == WR_WAIT);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      q_q       <= RESET_VAL;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign qOut      = q_q;
  assign mem_wdata = q_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// Randomized bench for mdr_mem_ctrl: a transaction-level MDR model predicts each
// completion/timeout pulse, and a negedge monitor pops and compares them.
module tb_mdr_mem_ctrl;

  localparam int          DATA_W    = 32;
  localparam int          NB        = DATA_W / 8;
  localparam int          MAX_WAIT  = 15;
  localparam logic [31:0] RESET_VAL = 32'h5;

  logic              clk;
  logic              clr;
  logic              enable;
  logic              read_req;
  logic              write_req;
  logic [NB-1:0]     byte_en;
  logic [DATA_W-1:0] BusMuxOut;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [DATA_W-1:0] qOut;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic              busy;
  logic              done;
  logic              timeout;

  mdr_mem_ctrl #(
    .DATA_W    (DATA_W),
    .RESET_VAL (RESET_VAL),
    .MAX_WAIT  (MAX_WAIT)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .enable    (enable),
    .read_req  (read_req),
    .write_req (write_req),
    .byte_en   (byte_en),
    .BusMuxOut (BusMuxOut),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .qOut      (qOut),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int                vectors     = 0;
  int                miscompares = 0;
  logic [33:0]       exp_q[$];     // {done, timeout, qOut}
  logic [DATA_W-1:0] q_model;
  logic [33:0]       mon_got;
  logic [33:0]       mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enable    = 1'b0;
    read_req  = 1'b0;
    write_req = 1'b0;
    byte_en   = '0;
    BusMuxOut = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
  endtask

  task automatic stray_inputs();
    enable    = 1'($urandom_range(0, 1));
    read_req  = 1'($urandom_range(0, 1));
    write_req = 1'($urandom_range(0, 1));
    BusMuxOut = $urandom;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    byte_en   = 4'($urandom);
  endtask

  // Driver: IDLE load from the bus.
  task automatic do_load(input logic [31:0] v);
    idle_inputs();
    enable    = 1'b1;
    BusMuxOut = v;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    step();
    q_model = v;
    idle_inputs();
    check("load_q", 64'(qOut), 64'(q_model));
    check("load_busy", 64'(busy), 64'd0);
  endtask

  // Driver: one read or write. ready_cycle = wait cycle carrying mem_ready, 0 = never.
  task automatic do_xfer(input bit is_wr, input logic [NB-1:0] be, input logic [31:0] rdata,
                         input int ready_cycle, input bit all_req);
    int strobe_cycles;
    int exp_cycles;
    idle_inputs();
    read_req  = !is_wr;
    write_req = is_wr ? 1'b1 : (all_req ? 1'b1 : 1'($urandom_range(0, 1)));
    enable    = all_req ? 1'b1 : 1'($urandom_range(0, 1));
    BusMuxOut = $urandom;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    byte_en   = 4'($urandom);
    step();

    // Reference outcome of the whole transaction.
    if (ready_cycle != 0) begin
      if (!is_wr) begin
        for (int i = 0; i < NB; i++) begin
          if (be[i]) q_model[8*i +: 8] = rdata[8*i +: 8];
        end
      end
      exp_q.push_back({2'b10, q_model});
      exp_cycles = ready_cycle;
    end else begin
      exp_q.push_back({2'b01, q_model});
      exp_cycles = MAX_WAIT;
    end

    strobe_cycles = 0;
    for (int k = 1; k <= MAX_WAIT; k++) begin
      if (busy && (is_wr ? (mem_wr && !mem_rd) : (mem_rd && !mem_wr))) strobe_cycles++;
      if (is_wr) check("wr_wdata", 64'(mem_wdata), 64'(q_model));
      stray_inputs();
      mem_ready = (k == ready_cycle);
      if (k == ready_cycle) begin
        mem_rdata = rdata;
        byte_en   = be;
      end
      step();
      if (k == ready_cycle) break;
    end
    check(is_wr ? "wr_cycles" : "rd_cycles", 64'(strobe_cycles), 64'(exp_cycles));
    check("strobes_off", 64'({mem_rd, mem_wr, busy}), 64'd0);

    if (ready_cycle != 0) begin
      stray_inputs();
      step();
      idle_inputs();
      check("done_one_cycle", 64'(done), 64'd0);
    end else begin
      idle_inputs();
      step();
      check("timeout_one_cycle", 64'(timeout), 64'd0);
    end
    check("q_after", 64'(qOut), 64'(q_model));
  endtask

  // Monitor: every done/timeout pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (clr && (done || timeout)) begin
      mon_got = {done, timeout, qOut};
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: got done=%b timeout=%b qOut=%0h with nothing expected",
                 done, timeout, qOut);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pulse", 64'(mon_got), 64'(mon_exp));
      end
    end
  end

  initial begin
    idle_inputs();
    clr = 1'b0;
    #12;
    check("rst_qOut", 64'(qOut), 64'(RESET_VAL));
    check("rst_flags", 64'({mem_rd, mem_wr, busy, done, timeout}), 64'd0);
    @(negedge clk);
    clr = 1'b1;
    q_model = RESET_VAL;

    do_load(32'h12345678);
    check("load_const", 64'(qOut), 64'h12345678);

    do_load(32'hAABBCCDD);
    do_xfer(1'b0, 4'b0101, 32'h11223344, 3, 1'b0);
    check("merge_const", 64'(qOut), 64'hAA22CC44);

    do_load(32'hCAFEF00D);
    do_xfer(1'b1, '0, '0, 2, 1'b0);
    check("write_keep", 64'(qOut), 64'hCAFEF00D);

    do_xfer(1'b0, 4'($urandom), $urandom, 0, 1'b0);
    do_xfer(1'b0, 4'hF, $urandom, MAX_WAIT, 1'b0);
    do_xfer(1'b1, '0, '0, MAX_WAIT, 1'b0);
    do_xfer(1'b0, 4'h0, $urandom, 1, 1'b1);
    do_xfer(1'b1, '0, '0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0:       do_load($urandom);
        1:       do_xfer(1'b0, 4'($urandom), $urandom, $urandom_range(0, MAX_WAIT), 1'($urandom_range(0, 1)));
        default: do_xfer(1'b1, '0, '0, $urandom_range(0, MAX_WAIT), 1'b0);
      endcase
    end

    // Asynchronous clear in the middle of a read wait.
    do_load(32'hDEADBEEF);
    read_req = 1'b1;
    step();
    read_req = 1'b0;
    repeat (3) step();
    #2;
    clr = 1'b0;
    #1;
    check("clr_qOut", 64'(qOut), 64'(RESET_VAL));
    check("clr_flags", 64'({mem_rd, mem_wr, busy, done, timeout}), 64'd0);
    q_model = RESET_VAL;
    @(negedge clk);
    clr = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = $urandom;
    byte_en   = 4'hF;
    for (int k = 0; k < 5; k++) begin
      step();
      check("post_clr_q", 64'(qOut), 64'(q_model));
      check("post_clr_busy", 64'(busy), 64'd0);
    end
    idle_inputs();

    do_load(32'h0BADF00D);
    do_xfer(1'b0, 4'b1000, 32'h77000000, 4, 1'b0);
    check("post_clr_read", 64'(qOut), 64'h77ADF00D);

    repeat (2) step();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
